// File: rtl/videomem_pkg.sv
// Shared types and defaults for the video-memory read burst engine.
// clog2 gives counter widths from the parameters at elaboration time.
package videomem_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int ADDR_W_DEF          = 25;
    localparam int DATA_W_DEF          = 16;
    localparam int BURST_LEN_DEF       = 8;
    localparam int MAX_OUTSTANDING_DEF = 4;

    // Number of bits needed to index v distinct values (minimum 1).
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/videomem_rd_burst_if.sv
// Request, SDRAM command and returned-data signals of the burst engine.
// slave is the engine's view; master is the surrounding system's view.
interface videomem_rd_burst_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic              read_request;
    logic [ADDR_W-1:0] read_addr;
    logic              read_req_ack;
    logic              mem_ready;
    logic              flush;
    logic              flush_done;
    logic              cmd_valid;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_ready;
    logic [DATA_W-1:0] ctrl_rdata;
    logic              ctrl_rdata_valid;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              burst_done;
    logic              err_unexpected;

    modport slave (
        input  read_request, read_addr, flush, cmd_ready, ctrl_rdata, ctrl_rdata_valid,
        output read_req_ack, mem_ready, flush_done, cmd_valid, cmd_addr,
               rdata, rdata_valid, burst_done, err_unexpected
    );

    modport master (
        output read_request, read_addr, flush, cmd_ready, ctrl_rdata, ctrl_rdata_valid,
        input  read_req_ack, mem_ready, flush_done, cmd_valid, cmd_addr,
               rdata, rdata_valid, burst_done, err_unexpected
    );
endinterface

// File: rtl/videomem_beat_counter.sv
// Counts returned beats within a burst, forwards them with one cycle of
// latency and flags the last beat of every burst.
module videomem_beat_counter
    import videomem_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              beat_en,
    input  logic [DATA_W-1:0] beat_data,
    output logic              last_beat,
    output logic              beat_idle,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              burst_done
);
    localparam int BEAT_W = clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    logic [BEAT_W-1:0] beat_reg;

    assign last_beat = beat_en && (beat_reg == BEAT_LAST);
    assign beat_idle = (beat_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_reg    <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            burst_done  <= 1'b0;
        end else begin
            rdata_valid <= beat_en;
            burst_done  <= last_beat;
            if (beat_en) begin
                rdata    <= beat_data;
                beat_reg <= last_beat ? '0 : beat_reg + BEAT_W'(1);
            end
        end
    end
endmodule

// File: rtl/videomem_rd_burst.sv
// Burst read engine: accepts requests, issues SDRAM commands, tracks
// outstanding bursts and drains everything in flight on a frame flush.
module videomem_rd_burst
    import videomem_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int BURST_LEN       = BURST_LEN_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                mem_clock,
    input  logic                reset_n,
    videomem_rd_burst_if.slave  bus
);
    localparam int OUT_W = clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W:0] MAX_INFLIGHT = (OUT_W + 1)'(MAX_OUTSTANDING);

    state_t            state_reg;
    logic              cmd_valid_reg;
    logic [ADDR_W-1:0] cmd_addr_reg;
    logic [OUT_W-1:0]  outstanding_reg;
    logic              mem_ready_reg;
    logic              flush_done_reg;
    logic              err_reg;

    logic              free;
    logic [OUT_W:0]    in_flight;
    logic              ack;
    logic              cmd_fire;
    logic              beat_en;
    logic              last_beat;
    logic              beat_idle;
    logic              drain_done;
    logic              run_next;
    logic              cmd_valid_next;
    logic [OUT_W-1:0]  outstanding_next;
    logic              mem_ready_next;

    assign free      = !cmd_valid_reg || bus.cmd_ready;
    assign in_flight = {1'b0, outstanding_reg} + {{OUT_W{1'b0}}, cmd_valid_reg};
    assign ack       = bus.read_request && (state_reg == RUN) && free && (in_flight < MAX_INFLIGHT);
    assign cmd_fire  = cmd_valid_reg && bus.cmd_ready;
    // Beats arriving with nothing outstanding never reach the beat counter.
    assign beat_en   = bus.ctrl_rdata_valid && (outstanding_reg != '0);

    assign drain_done = (state_reg == DRAIN) && !cmd_valid_reg
                        && (outstanding_reg == '0) && beat_idle;
    assign run_next   = ((state_reg == RUN) && !bus.flush) || drain_done;

    always_comb begin
        cmd_valid_next = cmd_valid_reg;
        if (ack) begin
            cmd_valid_next = 1'b1;
        end else if (cmd_fire) begin
            cmd_valid_next = 1'b0;
        end
    end

    always_comb begin
        outstanding_next = outstanding_reg;
        case ({cmd_fire, last_beat})
            2'b10:   outstanding_next = outstanding_reg + OUT_W'(1);
            2'b01:   outstanding_next = outstanding_reg - OUT_W'(1);
            default: outstanding_next = outstanding_reg;
        endcase
    end

    assign mem_ready_next = run_next
        && (({1'b0, outstanding_next} + {{OUT_W{1'b0}}, cmd_valid_next}) < MAX_INFLIGHT);

    always_ff @(posedge mem_clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid_reg   <= 1'b0;
            cmd_addr_reg    <= '0;
            outstanding_reg <= '0;
            mem_ready_reg   <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            cmd_valid_reg   <= cmd_valid_next;
            outstanding_reg <= outstanding_next;
            mem_ready_reg   <= mem_ready_next;
            if (ack) begin
                cmd_addr_reg <= bus.read_addr;
            end
            if (bus.ctrl_rdata_valid && (outstanding_reg == '0)) begin
                err_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge mem_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= RUN;
            flush_done_reg <= 1'b0;
        end else begin
            flush_done_reg <= 1'b0;
            case (state_reg)
                RUN: begin
                    if (bus.flush) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_reg      <= RUN;
                        flush_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    videomem_beat_counter #(
        .BURST_LEN (BURST_LEN),
        .DATA_W    (DATA_W)
    ) u_beat_counter (
        .clk         (mem_clock),
        .rst_n       (reset_n),
        .beat_en     (beat_en),
        .beat_data   (bus.ctrl_rdata),
        .last_beat   (last_beat),
        .beat_idle   (beat_idle),
        .rdata       (bus.rdata),
        .rdata_valid (bus.rdata_valid),
        .burst_done  (bus.burst_done)
    );

    assign bus.read_req_ack   = ack;
    assign bus.mem_ready      = mem_ready_reg;
    assign bus.flush_done     = flush_done_reg;
    assign bus.cmd_valid      = cmd_valid_reg;
    assign bus.cmd_addr       = cmd_addr_reg;
    assign bus.err_unexpected = err_reg;
endmodule

// File: tb/tb_videomem_rd_burst.sv
// Directed bench: stimulus pushes expected commands/beats into queues,
// negedge monitors pop and compare whenever the engine presents output.
module tb_videomem_rd_burst;
    import videomem_pkg::*;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic mem_clock = 1'b0;
    logic reset_n   = 1'b0;

    videomem_rd_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    videomem_rd_burst #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .BURST_LEN       (8),
        .MAX_OUTSTANDING (4)
    ) dut (
        .mem_clock (mem_clock),
        .reset_n   (reset_n),
        .bus       (bus.slave)
    );

    always #5 mem_clock = ~mem_clock;

    int checks  = 0;
    int errors  = 0;
    int ack_cnt = 0;
    logic [ADDR_W-1:0] exp_cmd[$];
    beat_t             exp_rd[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic spurious(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=0x%0h expected=none", name, act);
    endtask

    task automatic tick();
        @(posedge mem_clock);
        #1;
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input logic last, input bit fwd);
        bus.ctrl_rdata       = d;
        bus.ctrl_rdata_valid = 1'b1;
        if (fwd) exp_rd.push_back('{data: d, last: last});
        tick();
        bus.ctrl_rdata_valid = 1'b0;
    endtask

    task automatic burst(input logic [DATA_W-1:0] base);
        for (int i = 0; i < 8; i++) beat(base + DATA_W'(i), i == 7, 1'b1);
    endtask

    // Request driver: each accepted address becomes an expected command.
    always @(negedge mem_clock) begin
        if (reset_n && bus.read_request && bus.read_req_ack) begin
            exp_cmd.push_back(bus.read_addr);
            ack_cnt++;
            $display("ack  addr=0x%07h", bus.read_addr);
            @(posedge mem_clock);
            #1;
            bus.read_addr = bus.read_addr + ADDR_W'(1);
        end
    end

    always @(negedge mem_clock) begin
        if (reset_n && bus.cmd_valid && bus.cmd_ready) begin
            $display("cmd  addr=0x%07h", bus.cmd_addr);
            if (exp_cmd.size() == 0) spurious("cmd_spurious", 32'(bus.cmd_addr));
            else check("cmd_addr", 32'(bus.cmd_addr), 32'(exp_cmd.pop_front()));
        end
    end

    always @(negedge mem_clock) begin
        beat_t e;
        if (bus.rdata_valid) begin
            $display("beat data=0x%04h burst_done=%0b", bus.rdata, bus.burst_done);
            if (exp_rd.size() == 0) spurious("rdata_spurious", 32'(bus.rdata));
            else begin
                e = exp_rd.pop_front();
                check("rdata", 32'(bus.rdata), 32'(e.data));
                check("burst_done", 32'(bus.burst_done), 32'(e.last));
            end
        end else if (bus.burst_done) begin
            spurious("burst_done_no_data", 32'(bus.burst_done));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] a;
        int ack0;

        bus.read_request     = 1'b0;
        bus.read_addr        = '0;
        bus.flush            = 1'b0;
        bus.cmd_ready        = 1'b0;
        bus.ctrl_rdata       = '0;
        bus.ctrl_rdata_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge mem_clock);
        @(negedge mem_clock);
        check("rst_cmd_valid",  32'(bus.cmd_valid), 0);
        check("rst_cmd_addr",   32'(bus.cmd_addr), 0);
        check("rst_mem_ready",  32'(bus.mem_ready), 0);
        check("rst_ack",        32'(bus.read_req_ack), 0);
        check("rst_flush_done", 32'(bus.flush_done), 0);
        check("rst_rdata",      32'(bus.rdata), 0);
        check("rst_rdata_valid",32'(bus.rdata_valid), 0);
        check("rst_burst_done", 32'(bus.burst_done), 0);
        check("rst_err",        32'(bus.err_unexpected), 0);
        @(posedge mem_clock);
        #1;
        reset_n = 1'b1;
        tick();

        // 1: single request, one burst returned
        bus.cmd_ready    = 1'b1;
        bus.read_addr    = 25'h0000004;
        bus.read_request = 1'b1;
        @(negedge mem_clock);
        check("t1_ack", 32'(bus.read_req_ack), 1);
        tick();
        bus.read_request = 1'b0;
        @(negedge mem_clock);
        check("t1_cmd_valid", 32'(bus.cmd_valid), 1);
        tick();
        burst(16'h0100);
        tick();
        @(negedge mem_clock);
        check("t1_outstanding", 32'(dut.outstanding_reg), 0);
        check("t1_rd_queue", 32'(exp_rd.size()), 0);
        tick();

        // 2: saturate with no data, then release one burst
        ack0 = ack_cnt;
        bus.read_request = 1'b1;
        repeat (10) tick();
        @(negedge mem_clock);
        check("t2_acks", 32'(ack_cnt - ack0), 4);
        check("t2_ack_full", 32'(bus.read_req_ack), 0);
        check("t2_mem_ready_full", 32'(bus.mem_ready), 0);
        tick();
        burst(16'h0200);
        @(negedge mem_clock);
        check("t2_mem_ready_back", 32'(bus.mem_ready), 1);
        check("t2_ack_back", 32'(bus.read_req_ack), 1);
        tick();
        bus.read_request = 1'b0;
        for (int k = 0; k < 4; k++) burst(16'h0300 + 16'(k * 16));
        tick();
        @(negedge mem_clock);
        check("t2_cmd_queue", 32'(exp_cmd.size()), 0);
        check("t2_outstanding", 32'(dut.outstanding_reg), 0);
        tick();

        // 3: command stalled by cmd_ready
        bus.cmd_ready    = 1'b0;
        a                = bus.read_addr;
        bus.read_request = 1'b1;
        @(negedge mem_clock);
        check("t3_ack_first", 32'(bus.read_req_ack), 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge mem_clock);
            check("t3_addr_hold", 32'(bus.cmd_addr), 32'(a));
            check("t3_no_ack", 32'(bus.read_req_ack), 0);
            tick();
        end
        bus.cmd_ready = 1'b1;
        @(negedge mem_clock);
        check("t3_ack_on_ready", 32'(bus.read_req_ack), 1);
        tick();
        bus.read_request = 1'b0;
        tick();
        @(negedge mem_clock);
        check("t3_outstanding", 32'(dut.outstanding_reg), 2);
        tick();

        // 4: last beat coincides with a command accept
        for (int i = 0; i < 6; i++) beat(16'h0400 + 16'(i), 1'b0, 1'b1);
        bus.read_request = 1'b1;
        beat(16'h0406, 1'b0, 1'b1);
        bus.read_request = 1'b0;
        beat(16'h0407, 1'b1, 1'b1);
        @(negedge mem_clock);
        check("t4_outstanding", 32'(dut.outstanding_reg), 2);
        tick();
        burst(16'h0500);
        burst(16'h0510);
        tick();

        // 5: flush with two bursts outstanding
        bus.read_request = 1'b1;
        tick();
        tick();
        bus.read_request = 1'b0;
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush        = 1'b0;
        bus.read_request = 1'b1;
        ack0             = ack_cnt;
        @(negedge mem_clock);
        check("t5_mem_ready_drain", 32'(bus.mem_ready), 0);
        check("t5_ack_drain", 32'(bus.read_req_ack), 0);
        tick();
        burst(16'h0600);
        burst(16'h0610);
        @(negedge mem_clock);
        check("t5_flush_done_early", 32'(bus.flush_done), 0);
        check("t5_no_ack_drain", 32'(ack_cnt - ack0), 0);
        tick();
        @(negedge mem_clock);
        check("t5_flush_done", 32'(bus.flush_done), 1);
        check("t5_ack_after", 32'(bus.read_req_ack), 1);
        tick();
        bus.read_request = 1'b0;
        @(negedge mem_clock);
        check("t5_flush_done_pulse", 32'(bus.flush_done), 0);
        tick();
        burst(16'h0700);
        tick();

        // 6: unexpected data, then reset mid-burst
        beat(16'hDEAD, 1'b0, 1'b0);
        @(negedge mem_clock);
        check("t6_err", 32'(bus.err_unexpected), 1);
        check("t6_dropped", 32'(bus.rdata_valid), 0);
        repeat (3) tick();
        @(negedge mem_clock);
        check("t6_err_sticky", 32'(bus.err_unexpected), 1);
        tick();
        bus.read_request = 1'b1;
        tick();
        bus.read_request = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) beat(16'h0800 + 16'(i), 1'b0, i < 2);
        bus.ctrl_rdata       = 16'h0803;
        bus.ctrl_rdata_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_rdata_valid", 32'(bus.rdata_valid), 0);
        check("t6_rst_rdata", 32'(bus.rdata), 0);
        check("t6_rst_err", 32'(bus.err_unexpected), 0);
        check("t6_rst_mem_ready", 32'(bus.mem_ready), 0);
        check("t6_rst_outstanding", 32'(dut.outstanding_reg), 0);
        bus.ctrl_rdata_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 4; i < 8; i++) beat(16'h0800 + 16'(i), i == 7, 1'b0);
        @(negedge mem_clock);
        check("t6_err_after_rst", 32'(bus.err_unexpected), 1);
        check("t6_rd_queue", 32'(exp_rd.size()), 0);
        check("t6_cmd_queue", 32'(exp_cmd.size()), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
